// File: rtl/icache_direct_if.sv
// icache_direct_if: groups the fetch-side and memory-side signals of the
// instruction cache.
//   imemREN/imemaddr  datapath fetch request and address
//   ihit/imemload     fetch satisfied, fetched instruction
//   iREN/iaddr        memory read request and address
//   iwait/iload       memory busy flag and read data
// Modports:
//   slave  - the cache's view (consumes requests, drives results and memory reads)
//   master - the environment's view (datapath + memory controller)
interface icache_direct_if #(
  parameter int PC_W = 32
);
  logic            imemREN;
  logic [PC_W-1:0] imemaddr;
  logic            ihit;
  logic [PC_W-1:0] imemload;
  logic            iREN;
  logic [PC_W-1:0] iaddr;
  logic            iwait;
  logic [PC_W-1:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-block instruction cache between
// the fetch stage and the memory controller. Hits are served combinationally;
// a miss stalls the datapath (ihit=0), reads the word from memory and installs
// it, after which the lookup hits from the installed frame.
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   icache_direct_if.slave (fetch and memory handshake signals)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | lookup of imemaddr; a requested miss captures miss_addr
// MISS  | memory read of miss_addr held until iwait=0, then fill
module icache_direct #(
  parameter int SETS = 16,
  parameter int PC_W = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  icache_direct_if.slave  bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - 2 - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state_q, state_nxt;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [PC_W-1:0]  data_q [SETS];
  logic [PC_W-1:0]  miss_addr_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill;
  logic             capture;

  logic             ihit_c;
  logic [PC_W-1:0]  imemload_c;
  logic             iren_c;
  logic [PC_W-1:0]  iaddr_c;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[PC_W-1:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[PC_W-1:IDX_W+2];

  assign hit     = bus.imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign capture = (state_q == IDLE) && bus.imemREN && !hit;
  assign fill    = (state_q == MISS) && !bus.iwait;

  always_comb begin
    state_nxt  = state_q;
    ihit_c     = 1'b0;
    imemload_c = '0;
    iren_c     = 1'b0;
    iaddr_c    = '0;
    case (state_q)
      IDLE: begin
        ihit_c = hit;
        if (hit) imemload_c = data_q[req_idx];
        if (capture) state_nxt = MISS;
      end
      MISS: begin
        // The read address is the captured one, so a redirect of imemaddr
        // during the fill cannot corrupt the transaction in flight.
        iren_c  = 1'b1;
        iaddr_c = miss_addr_q;
        if (!bus.iwait) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ihit     = ihit_c;
  assign bus.imemload = imemload_c;
  assign bus.iREN     = iren_c;
  assign bus.iaddr    = iaddr_c;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q <= state_nxt;
      if (capture) miss_addr_q <= {bus.imemaddr[PC_W-1:2], 2'b00};
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data are only meaningful behind a set valid bit, so they carry
  // no reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;
  logic CLK;
  logic nRST;
  int   errors = 0;
  int   checks = 0;

  icache_direct_if #(.PC_W(32)) bus ();

  icache_direct #(.SETS(16), .PC_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Lookup-phase outputs: no memory traffic, hit/data as given.
  task automatic chk_idle(input string tag, input logic h, input logic [31:0] d);
    #1;
    chk({tag, ".ihit"}, {31'b0, bus.ihit}, {31'b0, h});
    chk({tag, ".imemload"}, bus.imemload, d);
    chk({tag, ".iREN"}, {31'b0, bus.iREN}, 32'd0);
    chk({tag, ".iaddr"}, bus.iaddr, 32'd0);
  endtask

  // Called right after the edge that entered MISS. Memory stays busy for
  // nwait cycles, then returns data; ends one edge later, back in IDLE.
  task automatic serve_miss(input string tag, input logic [31:0] addr,
                            input int nwait, input logic [31:0] data);
    for (int i = 0; i < nwait; i++) begin
      bus.iwait = 1'b1;
      #1;
      chk({tag, ".busy.iREN"}, {31'b0, bus.iREN}, 32'd1);
      chk({tag, ".busy.iaddr"}, bus.iaddr, addr);
      chk({tag, ".busy.ihit"}, {31'b0, bus.ihit}, 32'd0);
      tick();
    end
    bus.iwait = 1'b0;
    bus.iload = data;
    #1;
    chk({tag, ".last.iREN"}, {31'b0, bus.iREN}, 32'd1);
    chk({tag, ".last.iaddr"}, bus.iaddr, addr);
    chk({tag, ".last.imemload"}, bus.imemload, 32'd0);
    tick();
    bus.iwait = 1'b1;
    bus.iload = 32'hDEAD_BEEF;
  endtask

  initial begin
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'hDEAD_BEEF;
    #12;
    chk_idle("reset", 1'b0, 32'd0);
    nRST = 1'b1;
    tick();

    // Cold miss on 0x4: three busy cycles, hit on the cycle after the fill.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0004;
    chk_idle("cold.lookup", 1'b0, 32'd0);
    tick();
    serve_miss("cold", 32'h0000_0004, 3, 32'h2002_0005);
    chk_idle("cold.hit", 1'b1, 32'h2002_0005);

    // Offset bits ignored; no request means no hit.
    bus.imemaddr = 32'h0000_0007;
    chk_idle("offset.hit", 1'b1, 32'h2002_0005);
    bus.imemREN = 1'b0; bus.imemaddr = 32'h0000_0004;
    chk_idle("noreq", 1'b0, 32'd0);
    tick();
    bus.imemREN = 1'b1;
    chk_idle("rehit", 1'b1, 32'h2002_0005);
    tick();

    // Conflict on index 1 with a one-cycle fill, then 0x4 misses again.
    bus.imemaddr = 32'h0000_0044;
    chk_idle("conf.lookup", 1'b0, 32'd0);
    tick();
    serve_miss("conf", 32'h0000_0044, 0, 32'hAAAA_0044);
    chk_idle("conf.hit", 1'b1, 32'hAAAA_0044);
    bus.imemaddr = 32'h0000_0004;
    chk_idle("evict.lookup", 1'b0, 32'd0);
    tick();
    serve_miss("evict", 32'h0000_0004, 1, 32'h2002_0005);
    chk_idle("evict.hit", 1'b1, 32'h2002_0005);
    tick();

    // Redirect during the fill of 0x8.
    bus.imemaddr = 32'h0000_0008;
    chk_idle("redir.lookup", 1'b0, 32'd0);
    tick();
    bus.imemaddr = 32'h0000_0100;
    serve_miss("redir", 32'h0000_0008, 2, 32'h0000_0088);
    chk_idle("redir.new", 1'b0, 32'd0);
    tick();
    serve_miss("redir2", 32'h0000_0100, 1, 32'h0010_0100);
    chk_idle("redir2.hit", 1'b1, 32'h0010_0100);
    bus.imemaddr = 32'h0000_0008;
    chk_idle("redir.old.hit", 1'b1, 32'h0000_0088);
    tick();

    // Request dropped mid-fill of 0xC.
    bus.imemaddr = 32'h0000_000C;
    chk_idle("drop.lookup", 1'b0, 32'd0);
    tick();
    bus.imemREN = 1'b0;
    serve_miss("drop", 32'h0000_000C, 2, 32'h0000_00CC);
    chk_idle("drop.idle", 1'b0, 32'd0);
    bus.imemREN = 1'b1;
    chk_idle("drop.hit", 1'b1, 32'h0000_00CC);
    tick();

    // Unaligned miss address is word aligned on iaddr.
    bus.imemaddr = 32'h0000_0012;
    chk_idle("align.lookup", 1'b0, 32'd0);
    tick();
    serve_miss("align", 32'h0000_0010, 0, 32'h0000_0110);
    bus.imemaddr = 32'h0000_0010;
    chk_idle("align.hit", 1'b1, 32'h0000_0110);
    tick();

    // Reset asserted during MISS.
    bus.imemaddr = 32'h0000_0020;
    chk_idle("rst.lookup", 1'b0, 32'd0);
    tick();
    bus.iwait = 1'b1;
    #1;
    chk("rst.pre.iREN", {31'b0, bus.iREN}, 32'd1);
    chk("rst.pre.iaddr", bus.iaddr, 32'h0000_0020);
    nRST = 1'b0;
    chk_idle("rst.mid", 1'b0, 32'd0);
    #3;
    nRST = 1'b1;
    bus.imemaddr = 32'h0000_0004;
    chk_idle("rst.after.4", 1'b0, 32'd0);
    bus.imemaddr = 32'h0000_0008;
    chk_idle("rst.after.8", 1'b0, 32'd0);
    tick();
    chk("rst.after.miss.iaddr", bus.iaddr, 32'h0000_0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
